fwd_hazard_unit: RTL and testbench
==================================

Name: fwd_hazard_unit

Overview:
Control-side counterpart of the EX-stage operand forwarding muxes in the 5-stage pipelined CPU. It tracks destination registers in flight through shadow ID/EX, EX/MEM and MEM/WB stages. From that state it generates the 2-bit forwarding selects for both ALU operands, and the load-use stall/bubble request toward the PC, IF/ID and ID/EX registers. It also keeps a saturating count of load-use stalls for performance debug.

Parameters:
REG_AW, 5, register address width
CNT_W, 16, stall counter width

Ports:
clk_i  input  1  clock
rst_i  input  1  reset; asynchronous, active-high
id_valid_i  input  1  ID stage holds a real instruction
id_rs_i  input  REG_AW  ID source register 1
id_rt_i  input  REG_AW  ID source register 2
id_rd_i  input  REG_AW  ID destination (already rt/rd-selected)
id_regwrite_i  input  1  ID instruction writes the register file
id_memread_i  input  1  ID instruction is a load
flush_i  input  1  branch taken; kill the ID instruction
fwd_a_o  output  2  operand A select for the EX instruction
fwd_b_o  output  2  operand B select for the EX instruction
stall_o  output  1  hold PC and IF/ID; insert bubble into ID/EX
stall_cnt_o  output  CNT_W  saturating load-use stall count

Behaviour:
- Select encoding, fixed for the mux side: 2'b00 register-file value, 2'b01 MEM/WB write-back data, 2'b10 EX/MEM ALU result. 2'b11 is never driven.
- Shadow stages, updated on every rising clk_i:
  - IDEX {valid, rs, rt, rd, regwrite, memread}
  - EXMEM {valid, rd, regwrite}
  - MEMWB {valid, rd, regwrite}
- Stage update rules:
  - EXMEM <= IDEX and MEMWB <= EXMEM unconditionally; the pipeline never stalls below ID.
  - IDEX <= ID inputs when stall_o=0 and flush_i=0.
  - Otherwise IDEX.valid <= 0 (bubble); its other fields are don't-care but are cleared to 0.
- fwd_a_o, combinational from shadow state:
  - 2'b10 if EXMEM.valid & EXMEM.regwrite & EXMEM.rd!=0 & EXMEM.rd==IDEX.rs.
  - Else 2'b01 if MEMWB.valid & MEMWB.regwrite & MEMWB.rd!=0 & MEMWB.rd==IDEX.rs.
  - Else 2'b00.
  - Forced to 2'b00 when IDEX.valid=0.
- fwd_b_o: same rules using IDEX.rt.
- Priority: EX/MEM beats MEM/WB when both match (youngest producer wins).
- Register 0 is never forwarded.
- stall_o, combinational: id_valid_i & IDEX.valid & IDEX.memread & IDEX.rd!=0 & (IDEX.rd==id_rs_i | IDEX.rd==id_rt_i).
  - Exactly one stall cycle per load-use pair. After the bubble the load is in EXMEM and is not forwardable from there; its data reaches the EX instruction via MEMWB (select 01) one cycle later.
- flush_i and stall_o in the same cycle: flush wins for the bubble. stall_o is still reported; the PC side gives flush priority.
- stall_cnt_o increments by 1 on each clock edge where stall_o=1 and flush_i=0. It saturates at all-ones and never wraps.
- Reset (async assert, sync release by the system):
  - All shadow valid bits and fields go to 0; stall_cnt_o=0.
  - Hence fwd_a_o=fwd_b_o=2'b00 and stall_o=0 while rst_i=1.
  - Reset mid-stall clears the stall immediately; no partial state survives.
- Latency: the selects are valid in the same cycle the instruction occupies EX. There is no registered output delay.

Decomposition:
- Shared package cpu_pkg holds:
  - the FWD_RF=2'b00, FWD_WB=2'b01 and FWD_MEM=2'b10 constants, used by this block and by both operand muxes;
  - REG_AW;
  - a shadow-stage struct typedef {valid, rd, regwrite}.
- One natural sub-module: fwd_sel, a combinational per-operand comparator instantiated twice (operand A on rs, operand B on rt).

Test Plan:
1. add r3 then next instruction uses r3 as rs: in that instruction's EX cycle fwd_a_o=2'b10, fwd_b_o=2'b00, stall_o=0.
2. add r3, one unrelated instruction, then instruction with rt=r3: fwd_b_o=2'b01 in its EX cycle.
3. add r3, add r3, then use r3: fwd_a_o=2'b10 (EX/MEM priority), not 01.
4. lw r5 then use r5 as rt:
   - stall_o=1 for exactly one cycle and IDEX.valid=0 next cycle;
   - the consumer then sees fwd_b_o=2'b01;
   - stall_cnt_o increments 0->1.
5. Producer writes r0 with a consumer of r0, and lw r0 followed by a use of r0: fwd stays 2'b00 and stall_o stays 0.
6. Assert rst_i asynchronously during a stall cycle: stall_o, fwd_a_o, fwd_b_o and stall_cnt_o drop to 0 before the next clock edge. Separately, a forced counter at all-ones plus a further stall holds at all-ones.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: forwarding select encodings, register address width and shadow-stage types
package cpu_pkg;
   localparam int REG_AW = 5;
   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;
   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] rd;
      logic              regwrite;
   } stage_t;
   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] rs;
      logic [REG_AW-1:0] rt;
      logic [REG_AW-1:0] rd;
      logic              regwrite;
      logic              memread;
   } idex_t;
endpackage

// File: rtl/fwd_sel.sv
// fwd_sel: per-operand forwarding select; the youngest producer (EX/MEM) wins, r0 never forwards
module fwd_sel
   import cpu_pkg::*;
(
   input  logic              idex_valid_i,
   input  logic [REG_AW-1:0] src_i,
   input  logic              mem_valid_i,
   input  logic [REG_AW-1:0] mem_rd_i,
   input  logic              mem_we_i,
   input  logic              wb_valid_i,
   input  logic [REG_AW-1:0] wb_rd_i,
   input  logic              wb_we_i,
   output logic [1:0]        sel_o
);
   logic mem_hit, wb_hit;
   always_comb begin
      mem_hit = mem_valid_i & mem_we_i & (mem_rd_i != '0) & (mem_rd_i == src_i);
      wb_hit  = wb_valid_i & wb_we_i & (wb_rd_i != '0) & (wb_rd_i == src_i);
      sel_o   = !idex_valid_i ? FWD_RF : mem_hit ? FWD_MEM : wb_hit ? FWD_WB : FWD_RF;
   end
endmodule

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: shadows ID/EX, EX/MEM, MEM/WB destinations to drive EX forwarding selects,
// the load-use stall request and a saturating stall counter.
module fwd_hazard_unit
   import cpu_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              id_valid_i,
   input  logic [REG_AW-1:0] id_rs_i,
   input  logic [REG_AW-1:0] id_rt_i,
   input  logic [REG_AW-1:0] id_rd_i,
   input  logic              id_regwrite_i,
   input  logic              id_memread_i,
   input  logic              flush_i,
   output logic [1:0]        fwd_a_o,
   output logic [1:0]        fwd_b_o,
   output logic              stall_o,
   output logic [CNT_W-1:0]  stall_cnt_o
);
   idex_t             idex_q, idex_d;
   stage_t            exmem_q, exmem_d, memwb_q, memwb_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   always_comb begin
      stall_o = id_valid_i & idex_q.valid & idex_q.memread & (idex_q.rd != '0) &
                ((idex_q.rd == id_rs_i) | (idex_q.rd == id_rt_i));
      // a flushed or stalled slot becomes a fully cleared bubble
      idex_d  = (stall_o | flush_i) ? '0 :
                '{id_valid_i, id_rs_i, id_rt_i, id_rd_i, id_regwrite_i, id_memread_i};
      exmem_d = '{idex_q.valid, idex_q.rd, idex_q.regwrite};
      memwb_d = exmem_q;
      cnt_d   = (stall_o & ~flush_i & ~&cnt_q) ? cnt_q + 1'b1 : cnt_q;
   end
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         idex_q  <= '0;
         exmem_q <= '0;
         memwb_q <= '0;
         cnt_q   <= '0;
      end else begin
         idex_q  <= idex_d;
         exmem_q <= exmem_d;
         memwb_q <= memwb_d;
         cnt_q   <= cnt_d;
      end
   end
   assign stall_cnt_o = cnt_q;
   fwd_sel u_sel_a (
      .idex_valid_i(idex_q.valid), .src_i(idex_q.rs),
      .mem_valid_i(exmem_q.valid), .mem_rd_i(exmem_q.rd), .mem_we_i(exmem_q.regwrite),
      .wb_valid_i(memwb_q.valid), .wb_rd_i(memwb_q.rd), .wb_we_i(memwb_q.regwrite),
      .sel_o(fwd_a_o)
   );
   fwd_sel u_sel_b (
      .idex_valid_i(idex_q.valid), .src_i(idex_q.rt),
      .mem_valid_i(exmem_q.valid), .mem_rd_i(exmem_q.rd), .mem_we_i(exmem_q.regwrite),
      .wb_valid_i(memwb_q.valid), .wb_rd_i(memwb_q.rd), .wb_we_i(memwb_q.regwrite),
      .sel_o(fwd_b_o)
   );
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: directed instruction sequences checked against an in-bench pipeline model
module tb_fwd_hazard_unit;
   localparam int CW   = 4;
   localparam int CMAX = (1 << CW) - 1;
   logic          clk_i = 0, rst_i = 1;
   logic          id_valid_i = 0, id_regwrite_i = 0, id_memread_i = 0, flush_i = 0;
   logic [4:0]    id_rs_i = 0, id_rt_i = 0, id_rd_i = 0;
   logic [1:0]    fwd_a_o, fwd_b_o;
   logic          stall_o;
   logic [CW-1:0] stall_cnt_o;
   int            n_vec = 0, n_err = 0;

   fwd_hazard_unit #(.CNT_W(CW)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .id_valid_i(id_valid_i), .id_rs_i(id_rs_i),
      .id_rt_i(id_rt_i), .id_rd_i(id_rd_i), .id_regwrite_i(id_regwrite_i),
      .id_memread_i(id_memread_i), .flush_i(flush_i), .fwd_a_o(fwd_a_o),
      .fwd_b_o(fwd_b_o), .stall_o(stall_o), .stall_cnt_o(stall_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   // model: index 0 = instruction in EX, 1 = in MEM, 2 = in WB
   logic       mv[3], mwe[3], mld[3];
   logic [4:0] mrd[3];
   logic [4:0] mrs, mrt;
   int         exp_cnt;

   function automatic logic [1:0] exp_fwd(input logic [4:0] s);
      if (!mv[0] || s == 0) return 2'b00;
      for (int k = 1; k < 3; k++)
         if (mv[k] && mwe[k] && mrd[k] == s) return (k == 1) ? 2'b10 : 2'b01;
      return 2'b00;
   endfunction

   function automatic logic exp_stall();
      return id_valid_i && mv[0] && mld[0] && mrd[0] != 0 && (mrd[0] == id_rs_i || mrd[0] == id_rt_i);
   endfunction

   always @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int k = 0; k < 3; k++) begin
            mv[k] = 0; mwe[k] = 0; mld[k] = 0; mrd[k] = 0;
         end
         mrs = 0; mrt = 0; exp_cnt = 0;
      end else begin
         logic st;
         st = exp_stall();
         if (st && !flush_i && exp_cnt < CMAX) exp_cnt++;
         for (int k = 2; k > 0; k--) begin
            mv[k] = mv[k-1]; mwe[k] = mwe[k-1]; mld[k] = mld[k-1]; mrd[k] = mrd[k-1];
         end
         if (st || flush_i) begin
            mv[0] = 0; mwe[0] = 0; mld[0] = 0; mrd[0] = 0; mrs = 0; mrt = 0;
         end else begin
            mv[0] = id_valid_i; mwe[0] = id_regwrite_i; mld[0] = id_memread_i;
            mrd[0] = id_rd_i; mrs = id_rs_i; mrt = id_rt_i;
         end
      end
   end

   task automatic chk(input string name, input int act, input int req);
      n_vec++;
      if (act != req) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
      end
   endtask

   always @(negedge clk_i) begin
      chk("model_fwd_a", fwd_a_o, exp_fwd(mrs));
      chk("model_fwd_b", fwd_b_o, exp_fwd(mrt));
      chk("model_stall", stall_o, exp_stall());
      chk("model_cnt", stall_cnt_o, exp_cnt);
   end

   // present one ID-stage instruction for a cycle; -1 means no literal expectation
   task automatic step(input logic v, input int rs, input int rt, input int rd, input logic we,
                       input logic ld, input logic fl, input int ea, input int eb, input int es);
      @(posedge clk_i);
      #1;
      id_valid_i = v; id_rs_i = 5'(rs); id_rt_i = 5'(rt); id_rd_i = 5'(rd);
      id_regwrite_i = we; id_memread_i = ld; flush_i = fl;
      @(negedge clk_i);
      if (ea >= 0) chk("lit_fwd_a", fwd_a_o, ea);
      if (eb >= 0) chk("lit_fwd_b", fwd_b_o, eb);
      if (es >= 0) chk("lit_stall", stall_o, es);
   endtask

   task automatic nop(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, -1, -1, -1);
   endtask

   initial begin
      #2;
      chk("reset_fwd_a", fwd_a_o, 0);
      chk("reset_fwd_b", fwd_b_o, 0);
      chk("reset_stall", stall_o, 0);
      chk("reset_cnt", stall_cnt_o, 0);
      @(negedge clk_i);
      #1 rst_i = 0;
      // EX/MEM forward to operand A
      step(1, 1, 2, 3, 1, 0, 0, -1, -1, -1);
      step(1, 3, 4, 8, 1, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 2, 0, 0);
      nop(2);
      // MEM/WB forward to operand B
      step(1, 1, 2, 3, 1, 0, 0, -1, -1, -1);
      step(1, 1, 2, 7, 1, 0, 0, -1, -1, -1);
      step(1, 4, 3, 9, 1, 0, 0, -1, -1, -1);
      step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      nop(2);
      // two producers of r3: youngest wins
      step(1, 1, 2, 3, 1, 0, 0, -1, -1, -1);
      step(1, 1, 2, 3, 1, 0, 0, -1, -1, -1);
      step(1, 3, 0, 9, 1, 0, 0, -1, -1, -1);
      step(0, 0, 0, 0, 0, 0, 0, 2, 0, 0);
      nop(2);
      // load-use: one stall, then forward from MEM/WB
      step(1, 1, 0, 5, 1, 1, 0, -1, -1, -1);
      step(1, 6, 5, 10, 1, 0, 0, -1, -1, 1);
      step(1, 6, 5, 10, 1, 0, 0, 0, 0, 0);
      chk("lit_cnt_one", stall_cnt_o, 1);
      step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      nop(2);
      // r0 never forwarded nor stalled on
      step(1, 1, 2, 0, 1, 0, 0, -1, -1, -1);
      step(1, 0, 0, 11, 1, 0, 0, -1, -1, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step(1, 1, 0, 0, 1, 1, 0, -1, -1, -1);
      step(1, 0, 0, 11, 1, 0, 0, -1, -1, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      nop(2);
      // flush coinciding with stall: stall reported, no count, consumer killed
      step(1, 1, 0, 5, 1, 1, 0, -1, -1, -1);
      step(1, 5, 2, 12, 1, 0, 1, -1, -1, 1);
      step(1, 1, 2, 13, 1, 0, 0, 0, 0, 0);
      chk("lit_cnt_flush", stall_cnt_o, 1);
      nop(3);
      // async reset in the middle of a stall cycle
      step(1, 1, 0, 5, 1, 1, 0, -1, -1, -1);
      step(1, 5, 5, 14, 1, 0, 0, -1, -1, 1);
      #1 rst_i = 1;
      #1;
      chk("arst_stall", stall_o, 0);
      chk("arst_fwd_a", fwd_a_o, 0);
      chk("arst_fwd_b", fwd_b_o, 0);
      chk("arst_cnt", stall_cnt_o, 0);
      @(negedge clk_i);
      #1 rst_i = 0;
      // saturation: more load-use stalls than the counter can hold
      for (int i = 0; i < CMAX + 3; i++) begin
         step(1, 1, 0, 5, 1, 1, 0, -1, -1, -1);
         step(1, 5, 0, 6, 1, 0, 0, -1, -1, 1);
         step(1, 5, 0, 6, 1, 0, 0, -1, -1, 0);
      end
      nop(1);
      chk("lit_cnt_sat", stall_cnt_o, CMAX);
      nop(2);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
